// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM state encoding and the frame geometry live here.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int MAX_WORDS      = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    // A header is legal when it names between one and MAX_WORDS words.
    function automatic logic header_ok(input logic [7:0] n);
        return (n != 8'd0) && (n <= 8'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer with a running XOR checksum.
// The first byte of a word ends up in the most significant lane.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_data,
    output logic [DATA_W-1:0] word,
    output logic [7:0]        checksum,
    output logic              word_full
);

    logic [DATA_W-1:0] word_reg;
    logic [7:0]        checksum_reg;
    logic [IDX_W-1:0]  idx_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word_reg     <= '0;
            checksum_reg <= '0;
            idx_reg      <= '0;
        end else if (accept) begin
            word_reg     <= {word_reg[DATA_W-9:0], byte_data};
            checksum_reg <= checksum_reg ^ byte_data;
            idx_reg      <= idx_reg + IDX_W'(1);
        end
    end

    // Asserted in the same cycle as the byte that completes the word.
    assign word_full = accept && (idx_reg == IDX_W'(BYTES_PER_WORD - 1));
    assign word      = word_reg;
    assign checksum  = checksum_reg;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream into instruction memory and releases the
// core from reset only after a load completes with a matching checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WL_W = $clog2(MAX_WORDS + 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [WL_W-1:0]   words_left_reg, words_left_next;
    logic [TO_W-1:0]   timeout_reg, timeout_next;

    logic              receiving;
    logic              expired;
    logic              fire;
    logic              packer_clear;
    logic              packer_accept;
    logic              word_full;
    logic [7:0]        checksum;
    logic [DATA_W-1:0] packed_word;

    assign receiving = (state_reg == HDR) || (state_reg == DATA) || (state_reg == CHK);
    assign expired   = (timeout_reg == TO_W'(TIMEOUT_CYCLES));
    // Ready drops once the timeout expires so no byte is taken on the abort edge.
    assign byte_ready    = receiving && !expired;
    assign fire          = byte_valid && byte_ready;
    assign packer_accept = fire && (state_reg == DATA);

    imem_word_packer #(
        .DATA_W(DATA_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (packer_clear),
        .accept    (packer_accept),
        .byte_data (byte_data),
        .word      (packed_word),
        .checksum  (checksum),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            wr_ptr_reg     <= '0;
            words_left_reg <= '0;
            timeout_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            words_left_reg <= words_left_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        words_left_next = words_left_reg;
        timeout_next    = timeout_reg;
        packer_clear    = 1'b0;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next   = HDR;
                    wr_ptr_next  = '0;
                    timeout_next = '0;
                    packer_clear = 1'b1;
                end
            end
            HDR, DATA, CHK: begin
                if (expired) begin
                    state_next = ERR;
                end else if (fire) begin
                    timeout_next = '0;
                    case (state_reg)
                        HDR: begin
                            if (header_ok(byte_data)) begin
                                words_left_next = byte_data[WL_W-1:0];
                                state_next      = DATA;
                            end else begin
                                state_next = ERR;
                            end
                        end
                        DATA: begin
                            if (word_full) begin
                                state_next = WRITE;
                            end
                        end
                        default: begin
                            state_next = (byte_data == checksum) ? DONE : ERR;
                        end
                    endcase
                end else begin
                    timeout_next = timeout_reg + TO_W'(1);
                end
            end
            WRITE: begin
                wr_ptr_next     = wr_ptr_reg + ADDR_W'(1);
                words_left_next = words_left_reg - WL_W'(1);
                state_next      = (words_left_reg == WL_W'(1)) ? CHK : DATA;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The packed word stays stable through WRITE because ready is low there.
    assign imem_we    = (state_reg == WRITE);
    assign imem_addr  = wr_ptr_reg;
    assign imem_wdata = packed_word;
    assign core_hold  = (state_reg != DONE);
    assign load_done  = (state_reg == DONE);
    assign load_err   = (state_reg == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good, bad-checksum, illegal-header,
// full, timeout and mid-load-reset frames with hand-computed results.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [7:0]  frame[$];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W        (5),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte and wait (bounded) for it to be taken.
    task automatic send_byte(input logic [7:0] b, output int stalls);
        stalls     = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && stalls < 40) begin
            tick();
            stalls++;
        end
        if (!byte_ready) check("ready_wait", {31'd0, byte_ready}, 32'd1);
        else tick();
    endtask

    // Sends the global frame; counts bytes whose stall differs from one
    // bubble before each word after the first and before the checksum.
    task automatic send_frame(output int bubble_errs);
        int st;
        int exp_st;
        bubble_errs = 0;
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], st);
            exp_st = (i > 1 && ((i - 1) % 4) == 0) ? 1 : 0;
            if (st != exp_st) bubble_errs++;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"}, {31'd0, byte_ready}, 32'd0);
        check({pfx, "_we"},    {31'd0, imem_we},    32'd0);
        check({pfx, "_addr"},  {27'd0, imem_addr},  32'd0);
        check({pfx, "_wdata"}, imem_wdata,          32'd0);
        check({pfx, "_done"},  {31'd0, load_done},  32'd0);
        check({pfx, "_err"},   {31'd0, load_err},   32'd0);
        check({pfx, "_hold"},  {31'd0, core_hold},  32'd1);
    endtask

    task automatic load_frame1(input logic [7:0] last);
        frame = '{8'h02, 8'h00, 8'h62, 8'h20, 8'h20,
                  8'h8C, 8'h45, 8'h0B, 8'hB8, last};
    endtask

    initial begin
        int base;
        int bub;
        int st;
        logic [7:0] kb;

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        tick(); tick(); tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // 1: good load
        base = log_addr.size();
        load_frame1(8'h18);
        do_start();
        check("t1_hold_hdr", {31'd0, core_hold}, 32'd1);
        send_frame(bub);
        byte_valid = 1'b0;
        check("t1_bubbles", bub, 0);
        check("t1_nwrites", log_addr.size() - base, 2);
        check("t1_addr0", {27'd0, log_addr[base]}, 32'd0);
        check("t1_data0", log_data[base], 32'h00622020);
        check("t1_addr1", {27'd0, log_addr[base+1]}, 32'd1);
        check("t1_data1", log_data[base+1], 32'h8C450BB8);
        check("t1_done", {31'd0, load_done}, 32'd1);
        check("t1_hold", {31'd0, core_hold}, 32'd0);
        check("t1_err",  {31'd0, load_err},  32'd0);

        // 2: bad checksum, started from DONE
        base = log_addr.size();
        load_frame1(8'h19);
        do_start();
        check("t2_done_cleared", {31'd0, load_done}, 32'd0);
        check("t2_hold_set",     {31'd0, core_hold}, 32'd1);
        send_frame(bub);
        byte_valid = 1'b0;
        check("t2_nwrites", log_addr.size() - base, 2);
        check("t2_data1", log_data[base+1], 32'h8C450BB8);
        check("t2_err",  {31'd0, load_err},  32'd1);
        check("t2_hold", {31'd0, core_hold}, 32'd1);
        check("t2_done", {31'd0, load_done}, 32'd0);

        // 3: illegal headers 00 and 21
        base = log_addr.size();
        do_start();
        check("t3a_err_cleared", {31'd0, load_err}, 32'd0);
        send_byte(8'h00, st);
        byte_valid = 1'b0;
        check("t3a_err",   {31'd0, load_err},   32'd1);
        check("t3a_ready", {31'd0, byte_ready}, 32'd0);
        do_start();
        send_byte(8'h21, st);
        byte_valid = 1'b0;
        check("t3b_err", {31'd0, load_err}, 32'd1);
        check("t3_nwrites", log_addr.size() - base, 0);

        // 4: full 32-word load, word k = {k,k,k,k}, checksum 00
        base = log_addr.size();
        frame.delete();
        frame.push_back(8'h20);
        for (int k = 0; k < 32; k++) begin
            kb = 8'(k);
            for (int j = 0; j < 4; j++) frame.push_back(kb);
        end
        frame.push_back(8'h00);
        do_start();
        send_frame(bub);
        byte_valid = 1'b0;
        check("t4_bubbles", bub, 0);
        check("t4_nwrites", log_addr.size() - base, 32);
        for (int k = 0; k < 32; k++) begin
            kb = 8'(k);
            check($sformatf("t4_addr%0d", k), {27'd0, log_addr[base+k]}, k);
            check($sformatf("t4_data%0d", k), log_data[base+k], {kb, kb, kb, kb});
        end
        check("t4_done", {31'd0, load_done}, 32'd1);

        // 5: timeout after 02 00 62
        base = log_addr.size();
        frame = '{8'h02, 8'h00, 8'h62};
        do_start();
        send_frame(bub);
        byte_valid = 1'b0;
        repeat (16) tick();
        check("t5_err_early", {31'd0, load_err}, 32'd0);
        tick();
        check("t5_err", {31'd0, load_err}, 32'd1);
        check("t5_nwrites", log_addr.size() - base, 0);

        // 6: reset after word 0 is written, then a clean reload
        frame = '{8'h02, 8'h00, 8'h62, 8'h20, 8'h20};
        do_start();
        send_frame(bub);
        byte_valid = 1'b0;
        check("t6_we", {31'd0, imem_we}, 32'd1);
        tick();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        tick();
        base = log_addr.size();
        load_frame1(8'h18);
        do_start();
        send_frame(bub);
        byte_valid = 1'b0;
        check("t6_nwrites", log_addr.size() - base, 2);
        check("t6_addr0", {27'd0, log_addr[base]}, 32'd0);
        check("t6_data0", log_data[base], 32'h00622020);
        check("t6_done", {31'd0, load_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
